alien_bomb: RTL and testbench

- Enemy-side projectile engine: selects a firing alien column, drops one bomb downward one row per game tick, and reports whether it strikes the player's ship.
- Counterpart of the player bullet, travelling in the opposite direction on the same 32x16 cell grid.
- Sits beside the player bullet in the game core, driven by the same move-tick enable.
- Outputs feed the renderer (bomb position) and the lives/game-state logic (player_hit).

---
 rtl/alien_bomb.sv | 113 +++++++++++
 tb/tb_alien_bomb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alien_bomb.sv
// Enemy bomb engine: picks a firing column, drops one bomb a row per move tick, flags ship strikes.
// Optional BOMB_AIM_EN: the column scan starts at the player's column instead of the LFSR.
module alien_bomb #(
    parameter int unsigned COOLDOWN  = 8,
    parameter int unsigned SHIP_ROW  = 14,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [4:0]  posH,
    input  logic [31:0] alien_cols,
    input  logic [3:0]  alien_row,
    input  logic        shield_hit,
    output logic        flying,
    output logic [4:0]  bombX,
    output logic [3:0]  bombY,
    output logic        player_hit
);

    localparam int unsigned    CNT_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(COOLDOWN);
    localparam logic [3:0]     SHIP_Y     = 4'(SHIP_ROW);

    typedef enum logic [1:0] {StIdle, StSeek, StFall} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       col;
    logic [7:0]       lfsr;

    logic       lfsr_fb;
    logic [4:0] row_below;
    logic [3:0] launch_y;
    logic [4:0] start_col;
    logic       at_ship;
    logic       bomb_done;
    logic       strike;

    always_comb begin
        lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        // One row below the lowest aliens, clamped so the bomb never starts past the ship row.
        row_below = {1'b0, alien_row} + 5'd1;
        launch_y  = (row_below >= 5'(SHIP_ROW)) ? SHIP_Y : row_below[3:0];
`ifdef BOMB_AIM_EN
        start_col = posH;
`else
        start_col = lfsr[4:0];
`endif
        at_ship   = (bombY == SHIP_Y);
        // Shield hit outranks a ship strike and needs no move tick.
        bomb_done = (state == StFall) && (shield_hit || (enable && at_ship));
        strike    = (state == StFall) && !shield_hit && enable && at_ship && (bombX == posH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= CNT_RELOAD;
            col        <= 5'd0;
            lfsr       <= LFSR_SEED;
            flying     <= 1'b0;
            bombX      <= 5'd0;
            bombY      <= 4'd0;
            player_hit <= 1'b0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr_fb};
            player_hit <= strike;
            case (state)
                StIdle: begin
                    flying <= 1'b0;
                    if (enable) begin
                        if (cnt == '0) begin
                            state <= StSeek;
                            col   <= start_col;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                StSeek: begin
                    if (alien_cols == 32'd0) begin
                        state <= StIdle;
                        cnt   <= CNT_RELOAD;
                    end else if (alien_cols[col]) begin
                        state  <= StFall;
                        bombX  <= col;
                        bombY  <= launch_y;
                        flying <= 1'b1;
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                StFall: begin
                    if (bomb_done) begin
                        state  <= StIdle;
                        cnt    <= CNT_RELOAD;
                        flying <= 1'b0;
                        bombX  <= 5'd0;
                        bombY  <= 4'd0;
                    end else if (enable) begin
                        bombY <= bombY + 4'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= CNT_RELOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_bomb.sv
// Directed bench for alien_bomb with COOLDOWN=2: launch timing, fall, strike, miss, shield, reset, aim.
module tb_alien_bomb;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [4:0]  posH;
    logic [31:0] alien_cols;
    logic [3:0]  alien_row;
    logic        shield_hit;
    logic        flying;
    logic [4:0]  bombX;
    logic [3:0]  bombY;
    logic        player_hit;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mlfsr;
    logic [4:0] exp_col;

    alien_bomb #(.COOLDOWN(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .posH       (posH),
        .alien_cols (alien_cols),
        .alien_row  (alien_row),
        .shield_hit (shield_hit),
        .flying     (flying),
        .bombX      (bombX),
        .bombY      (bombY),
        .player_hit (player_hit)
    );

    always #5 clk = ~clk;

    // Reference column-select LFSR: Fibonacci, taps 8,6,5,4, free-running.
    always @(posedge clk) begin
        if (reset) mlfsr <= 8'hA5;
        else       mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fly(input string tag);
        for (int i = 0; i < 40 && !flying; i++) step(1'b0);
        check(tag, {31'd0, flying}, 32'd1);
    endtask

    task automatic launch(input string tag);
        repeat (3) step(1'b1);
        wait_fly(tag);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        posH       = 5'd10;
        alien_cols = 32'h0000_0400;
        alien_row  = 4'd3;
        shield_hit = 1'b0;
        step(1'b0);
        step(1'b0);
        check("rst_flying", {31'd0, flying}, 32'd0);
        check("rst_x", {27'd0, bombX}, 32'd0);
        check("rst_y", {28'd0, bombY}, 32'd0);
        check("rst_hit", {31'd0, player_hit}, 32'd0);
        reset = 1'b0;

        // Two enables leave cnt at 0; idle cycles alone must not launch.
        step(1'b1);
        step(1'b1);
        repeat (40) step(1'b0);
        check("cool_hold", {31'd0, flying}, 32'd0);
        step(1'b1);
        wait_fly("launch1");
        check("launch1_x", {27'd0, bombX}, 32'd10);
        check("launch1_y", {28'd0, bombY}, 32'd4);

        for (int k = 5; k <= 14; k++) begin
            step(1'b1);
            check("fall_y", {28'd0, bombY}, k);
        end
        step(1'b0);
        check("fall_hold_y", {28'd0, bombY}, 32'd14);
        check("fall_hold_fly", {31'd0, flying}, 32'd1);
        step(1'b1);
        check("strike_hit", {31'd0, player_hit}, 32'd1);
        check("strike_fly", {31'd0, flying}, 32'd0);
        check("strike_x", {27'd0, bombX}, 32'd0);
        check("strike_y", {28'd0, bombY}, 32'd0);
        step(1'b0);
        check("strike_pulse", {31'd0, player_hit}, 32'd0);

        // Miss: cooldown restarts after the bomb ends.
        posH = 5'd11;
        step(1'b1);
        step(1'b1);
        repeat (40) step(1'b0);
        check("cool2_hold", {31'd0, flying}, 32'd0);
        step(1'b1);
        wait_fly("launch2");
        check("launch2_x", {27'd0, bombX}, 32'd10);
        repeat (10) step(1'b1);
        check("miss_y14", {28'd0, bombY}, 32'd14);
        step(1'b1);
        check("miss_hit", {31'd0, player_hit}, 32'd0);
        check("miss_fly", {31'd0, flying}, 32'd0);

        // Shield without enable, then shield racing a ship strike.
        launch("launch3");
        repeat (3) step(1'b1);
        check("shield_y7", {28'd0, bombY}, 32'd7);
        shield_hit = 1'b1;
        step(1'b0);
        shield_hit = 1'b0;
        check("shield_fly", {31'd0, flying}, 32'd0);
        check("shield_y", {28'd0, bombY}, 32'd0);
        posH = 5'd10;
        launch("launch4");
        repeat (10) step(1'b1);
        check("race_y14", {28'd0, bombY}, 32'd14);
        shield_hit = 1'b1;
        step(1'b1);
        shield_hit = 1'b0;
        check("race_hit", {31'd0, player_hit}, 32'd0);
        check("race_fly", {31'd0, flying}, 32'd0);

        // No aliens: SEEK falls back to IDLE, later a lone column 31 fires.
        alien_cols = 32'd0;
        repeat (3) step(1'b1);
        step(1'b0);
        alien_cols = 32'h8000_0000;
        alien_row  = 4'd15;
        repeat (40) step(1'b0);
        check("empty_fly", {31'd0, flying}, 32'd0);
        launch("launch5");
        check("col31_x", {27'd0, bombX}, 32'd31);
        check("clamp_y", {28'd0, bombY}, 32'd14);
        posH = 5'd31;
        step(1'b1);
        check("col31_hit", {31'd0, player_hit}, 32'd1);

        // Reset mid-fall.
        alien_cols = 32'h0000_0400;
        alien_row  = 4'd3;
        launch("launch6");
        repeat (5) step(1'b1);
        check("pre_rst_y", {28'd0, bombY}, 32'd9);
        reset = 1'b1;
        step(1'b0);
        check("midrst_fly", {31'd0, flying}, 32'd0);
        check("midrst_x", {27'd0, bombX}, 32'd0);
        check("midrst_y", {28'd0, bombY}, 32'd0);
        check("midrst_hit", {31'd0, player_hit}, 32'd0);
        reset = 1'b0;

        // Full alien row: the launch column is the scan start column.
        alien_cols = 32'hFFFF_FFFF;
        posH       = 5'd20;
        step(1'b1);
        step(1'b1);
`ifdef BOMB_AIM_EN
        exp_col = 5'd20;
`else
        exp_col = mlfsr[4:0];
`endif
        step(1'b1);
        step(1'b0);
        check("start_fly", {31'd0, flying}, 32'd1);
        check("start_x", {27'd0, bombX}, {27'd0, exp_col});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
